// File: rtl/bhargava_ctrl_pkg.sv
// rtl/bhargava_ctrl_pkg.sv - shared state encoding and default constants for the stream controller
package bhargava_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_LOAD = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    localparam int DEF_KEY_HOLD = 2;
    localparam int DEF_TIMEOUT  = 65535;
    localparam int DEF_LEN_W    = 32;

    // States in which a new start request may be accepted.
    function automatic logic state_is_settled(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/bhargava_drain_watchdog.sv
// rtl/bhargava_drain_watchdog.sv - reloadable down-counter that expires after TIMEOUT idle drain cycles
module bhargava_drain_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Reload while not running or on every kick; otherwise count down one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_W'(TIMEOUT);
        end else if (!i_run || i_kick) begin
            r_cnt <= CNT_W'(TIMEOUT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // The TIMEOUT-th consecutive un-kicked cycle is the one that fires.
    assign o_expire = i_run && !i_kick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/bhargava_stream_ctrl.sv
// rtl/bhargava_stream_ctrl.sv - key load, byte streaming and drain supervision for the scrambler core
module bhargava_stream_ctrl
    import bhargava_ctrl_pkg::*;
#(
    parameter int KEY_HOLD = DEF_KEY_HOLD,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      key,
    input  logic             mode,
    input  logic [LEN_W-1:0] total_len,
    input  logic [7:0]       src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic [63:0]      core_key_in,
    output logic             core_mode_in,
    output logic             core_key_en,
    output logic [7:0]       core_mpeg_in,
    output logic             core_mpeg_in_en,
    output logic             core_stream_end,
    input  logic             core_prog_full,
    input  logic             core_out_en,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [LEN_W-1:0] in_cnt,
    output logic [LEN_W-1:0] out_cnt,
    output logic [LEN_W-1:0] stall_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_key;
    logic             r_mode;
    logic [LEN_W-1:0] r_total;
    logic [LEN_W-1:0] r_in_cnt;
    logic [LEN_W-1:0] r_out_cnt;
    logic [LEN_W-1:0] r_stall_cnt;
    logic [3:0]       r_hold_cnt;
    logic [7:0]       r_mpeg;
    logic             r_mpeg_en;
    logic             r_stream_end;
    logic             r_done;
    logic             r_err_timeout;
    logic             r_err_overrun;

    logic w_start_acc;
    logic w_in_stream;
    logic w_in_drain;
    logic w_src_ready;
    logic w_xfer;
    logic w_last_xfer;
    logic w_key_last;
    logic w_out_active;
    logic w_out_hit;
    logic w_out_reach;
    logic w_expire;
    logic w_set_done;
    logic w_set_timeout;
    logic w_set_overrun;

    assign w_start_acc  = start && state_is_settled(r_state);
    assign w_in_stream  = (r_state == ST_STREAM);
    assign w_in_drain   = (r_state == ST_DRAIN);
    assign w_src_ready  = w_in_stream && !core_prog_full && (r_in_cnt < r_total);
    assign w_xfer       = src_valid && w_src_ready;
    assign w_last_xfer  = w_xfer && ((r_in_cnt + LEN_W'(1)) == r_total);
    assign w_key_last   = (r_state == ST_KEY_LOAD) && (r_hold_cnt == 4'(KEY_HOLD - 1));
    assign w_out_active = core_out_en && (w_in_stream || w_in_drain);
    assign w_out_hit    = w_out_active && (r_out_cnt == r_total);
    // Completion is recognised in the same cycle as the final output byte.
    assign w_out_reach  = (r_out_cnt == r_total) ||
                          (core_out_en && ((r_out_cnt + LEN_W'(1)) == r_total));

    bhargava_drain_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_in_drain),
        .i_kick   (core_out_en),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; overrun takes priority over completion and timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_set_done    = 1'b0;
        w_set_timeout = 1'b0;
        w_set_overrun = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_start_acc) begin
                    w_state_nxt = ST_KEY_LOAD;
                end
            end
            ST_KEY_LOAD: begin
                if (w_key_last) begin
                    w_state_nxt = (r_total == '0) ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_out_hit) begin
                    w_state_nxt   = ST_ERROR;
                    w_set_overrun = 1'b1;
                end else if (w_last_xfer) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_hit) begin
                    w_state_nxt   = ST_ERROR;
                    w_set_overrun = 1'b1;
                end else if (w_out_reach) begin
                    w_state_nxt = ST_DONE;
                    w_set_done  = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt   = ST_ERROR;
                    w_set_timeout = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Key, mode and length are captured once per accepted start and held thereafter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_mode  <= 1'b0;
            r_total <= '0;
        end else if (w_start_acc) begin
            r_key   <= key;
            r_mode  <= mode;
            r_total <= total_len;
        end
    end

    // Counts KEY_LOAD cycles so key_en spans exactly KEY_HOLD cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_KEY_LOAD) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // One-cycle registered byte path into the core; data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mpeg    <= '0;
            r_mpeg_en <= 1'b0;
        end else begin
            r_mpeg_en <= w_xfer;
            if (w_xfer) begin
                r_mpeg <= src_data;
            end
        end
    end

    // stream_end rises alongside the last byte, or on the empty-stream drain entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stream_end <= 1'b0;
        end else if (w_start_acc) begin
            r_stream_end <= 1'b0;
        end else if (w_last_xfer || (w_key_last && (r_total == '0))) begin
            r_stream_end <= 1'b1;
        end
    end

    // Byte and stall counters, cleared on each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_in_cnt <= r_in_cnt + LEN_W'(1);
            end
            if (w_out_active && (r_out_cnt != '1)) begin
                r_out_cnt <= r_out_cnt + LEN_W'(1);
            end
            if (w_in_stream && core_prog_full && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + LEN_W'(1);
            end
        end
    end

    // Sticky completion and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else if (w_start_acc) begin
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            if (w_set_timeout) begin
                r_err_timeout <= 1'b1;
            end
            if (w_set_overrun) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    assign src_ready       = w_src_ready;
    assign core_key_in     = r_key;
    assign core_mode_in    = r_mode;
    assign core_key_en     = (r_state == ST_KEY_LOAD);
    assign core_mpeg_in    = r_mpeg;
    assign core_mpeg_in_en = r_mpeg_en;
    assign core_stream_end = r_stream_end;
    assign busy            = !state_is_settled(r_state);
    assign done            = r_done;
    assign err_timeout     = r_err_timeout;
    assign err_overrun     = r_err_overrun;
    assign in_cnt          = r_in_cnt;
    assign out_cnt         = r_out_cnt;
    assign stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_bhargava_stream_ctrl.sv
// tb/tb_bhargava_stream_ctrl.sv - self-checking bench for bhargava_stream_ctrl
module tb_bhargava_stream_ctrl;

    localparam int KH = 2;
    localparam int TO = 100;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   key;
    logic          mode;
    logic [LW-1:0] total_len;
    logic [7:0]    src_data;
    logic          src_valid;
    logic          src_ready;
    logic [63:0]   core_key_in;
    logic          core_mode_in;
    logic          core_key_en;
    logic [7:0]    core_mpeg_in;
    logic          core_mpeg_in_en;
    logic          core_stream_end;
    logic          core_prog_full;
    logic          core_out_en;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_overrun;
    logic [LW-1:0] in_cnt;
    logic [LW-1:0] out_cnt;
    logic [LW-1:0] stall_cnt;

    always #5 clk = ~clk;

    bhargava_stream_ctrl #(
        .KEY_HOLD (KH),
        .TIMEOUT  (TO),
        .LEN_W    (LW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .key             (key),
        .mode            (mode),
        .total_len       (total_len),
        .src_data        (src_data),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .core_key_in     (core_key_in),
        .core_mode_in    (core_mode_in),
        .core_key_en     (core_key_en),
        .core_mpeg_in    (core_mpeg_in),
        .core_mpeg_in_en (core_mpeg_in_en),
        .core_stream_end (core_stream_end),
        .core_prog_full  (core_prog_full),
        .core_out_en     (core_out_en),
        .busy            (busy),
        .done            (done),
        .err_timeout     (err_timeout),
        .err_overrun     (err_overrun),
        .in_cnt          (in_cnt),
        .out_cnt         (out_cnt),
        .stall_cnt       (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: source byte list, how many the spec says have been taken,
    // stall cycles, and timing relative to the edge that accepted start.
    byte unsigned src_q[$];
    int           edge_num = 0;
    int           start_edge = 0;
    bit           run_active = 0;
    bit           halted = 0;
    bit           se_check = 0;
    bit           rand_valid = 0;
    int           m_total = 0;
    int           m_sent = 0;
    int           m_stall = 0;
    int           rx_seen = 0;
    int           ke_cycles = 0;
    logic [63:0]  m_key;
    bit           m_mode;

    // Core loopback model.
    bit           loop_en = 1;
    bit [3:0]     pipe = '0;
    int           oe_budget = 1000000;
    int           oe_issued = 0;
    int           oe_driven = 0;
    int           last_oe_edge = 0;

    task automatic cycle();
        bit in_stream;
        bit exp_ready;
        bit exp_ke;
        bit xfer;
        bit oe;
        int d;
        #1;
        d = edge_num - start_edge;
        in_stream = run_active && !halted && (d >= KH) && (m_sent < m_total);
        exp_ready = in_stream && !core_prog_full;
        exp_ke    = run_active && (d >= 0) && (d < KH);
        checks++;
        if (src_ready !== exp_ready) begin
            errors++;
            $display("FAIL src_ready: got %b expected %b (edge %0d)", src_ready, exp_ready, edge_num);
        end
        checks++;
        if (core_key_en !== exp_ke) begin
            errors++;
            $display("FAIL key_en: got %b expected %b (edge %0d)", core_key_en, exp_ke, edge_num);
        end
        if (core_key_en === 1'b1) ke_cycles++;
        if (in_stream && core_prog_full) m_stall++;
        xfer = src_valid && exp_ready;
        oe   = core_out_en;
        @(posedge clk);
        edge_num++;
        if (oe) begin
            oe_driven++;
            last_oe_edge = edge_num;
        end
        #1;
        checks++;
        if (core_mpeg_in_en !== xfer) begin
            errors++;
            $display("FAIL mpeg_in_en: got %b expected %b (edge %0d)", core_mpeg_in_en, xfer, edge_num);
        end
        if (core_mpeg_in_en === 1'b1) rx_seen++;
        if (xfer) begin
            if (core_mpeg_in_en === 1'b1) begin
                checks++;
                if (core_mpeg_in !== src_q[m_sent]) begin
                    errors++;
                    $display("FAIL mpeg_in byte %0d: got %h expected %h", m_sent, core_mpeg_in, src_q[m_sent]);
                end
            end
            m_sent++;
        end
        if (se_check) begin
            checks++;
            if (core_stream_end !== (m_sent == m_total)) begin
                errors++;
                $display("FAIL stream_end: got %b expected %b (edge %0d)", core_stream_end, (m_sent == m_total), edge_num);
            end
        end
        src_valid = (m_sent < src_q.size()) && (!rand_valid || ($urandom_range(0, 2) != 0));
        src_data  = (m_sent < src_q.size()) ? src_q[m_sent] : 8'h00;
        if (loop_en) begin
            pipe = {pipe[2:0], core_mpeg_in_en};
            if (pipe[3] && (oe_issued < oe_budget)) begin
                core_out_en = 1'b1;
                oe_issued++;
            end else begin
                core_out_en = 1'b0;
            end
        end
    endtask

    task automatic do_start(input logic [63:0] k, input bit md, input int len, input int nbytes);
        src_q.delete();
        for (int i = 0; i < nbytes; i++) src_q.push_back(byte'($urandom_range(0, 255)));
        m_key = k; m_mode = md; m_total = len;
        m_sent = 0; m_stall = 0; rx_seen = 0; ke_cycles = 0;
        oe_issued = 0; oe_driven = 0; pipe = '0; core_out_en = 1'b0;
        halted = 0; run_active = 1; start_edge = edge_num + 1;
        key = k; mode = md; total_len = LW'(len);
        src_valid = (nbytes > 0); src_data = (nbytes > 0) ? src_q[0] : 8'h00;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({src_ready, core_key_in, core_mode_in, core_key_en, core_mpeg_in, core_mpeg_in_en,
             core_stream_end, busy, done, err_timeout, err_overrun, in_cnt, out_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero key_in=%h busy=%b done=%b in=%0d out=%0d",
                     core_key_in, busy, done, in_cnt, out_cnt);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        bit ok;
        loop_en = 1; oe_budget = 1000000; rand_valid = 0; se_check = 1;
        do_start(64'ha1b2c3d4e5f61234, 1'b1, 16, 16);
        run_until_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_finish: busy still %b", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
        checks++; if (ke_cycles != KH) begin errors++; $display("FAIL basic_key_en_len: got %0d expected %0d", ke_cycles, KH); end
        checks++; if (core_key_in !== 64'ha1b2c3d4e5f61234) begin errors++; $display("FAIL basic_key: got %h", core_key_in); end
        checks++; if (core_mode_in !== 1'b1) begin errors++; $display("FAIL basic_mode: got %b expected 1", core_mode_in); end
        checks++; if (in_cnt !== 32'd16 || out_cnt !== 32'd16) begin errors++; $display("FAIL basic_counts: in %0d out %0d expected 16", in_cnt, out_cnt); end
        checks++; if (rx_seen != 16) begin errors++; $display("FAIL basic_bytes: got %0d expected 16", rx_seen); end
        checks++; if (core_stream_end !== 1'b1) begin errors++; $display("FAIL basic_stream_end: got %b", core_stream_end); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL basic_stall: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_prog_full();
        bit ok;
        loop_en = 1; oe_budget = 1000000; rand_valid = 0; se_check = 1;
        do_start({$urandom, $urandom}, 1'b0, 16, 16);
        for (int i = 0; i < 50 && m_sent < 5; i++) cycle();
        core_prog_full = 1'b1;
        repeat (10) cycle();
        core_prog_full = 1'b0;
        run_until_idle(300, ok);
        checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL pf_done: done %b ok %b", done, ok); end
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL pf_stall: got %0d expected 10", stall_cnt); end
        checks++; if (stall_cnt !== LW'(m_stall)) begin errors++; $display("FAIL pf_stall_model: got %0d expected %0d", stall_cnt, m_stall); end
        checks++; if (rx_seen != 16 || in_cnt !== 32'd16) begin errors++; $display("FAIL pf_bytes: got %0d/%0d expected 16", rx_seen, in_cnt); end
    endtask

    task automatic test_zero_len();
        int n;
        loop_en = 1; se_check = 0;
        do_start({$urandom, $urandom}, 1'b0, 0, 0);
        n = 0;
        for (int i = 0; i < KH + 2; i++) begin
            cycle();
            n++;
            if (done === 1'b1) break;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b after %0d cycles", done, n); end
        checks++; if (core_stream_end !== 1'b1) begin errors++; $display("FAIL zero_stream_end: got %b expected 1", core_stream_end); end
        checks++; if (rx_seen != 0 || in_cnt !== 32'd0) begin errors++; $display("FAIL zero_bytes: got %0d expected 0", rx_seen); end
    endtask

    task automatic test_timeout();
        bit seen;
        int diff;
        loop_en = 1; oe_budget = 7; rand_valid = 0; se_check = 1;
        do_start({$urandom, $urandom}, 1'b1, 8, 8);
        seen = 0; diff = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            cycle();
            if (err_timeout === 1'b1) begin
                seen = 1;
                diff = edge_num - last_oe_edge;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_flag: err_timeout never set"); end
        checks++; if (diff != TO) begin errors++; $display("FAIL to_latency: got %0d expected %0d", diff, TO); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_state: done %b busy %b expected 0 0", done, busy); end
        checks++; if (out_cnt !== 32'd7 || oe_driven != 7) begin errors++; $display("FAIL to_out_cnt: got %0d expected 7", out_cnt); end
        oe_budget = 1000000;
    endtask

    task automatic test_overrun_busy_start();
        loop_en = 0; core_out_en = 1'b0; se_check = 1;
        do_start(64'h0123456789abcdef, 1'b0, 4, 0);
        repeat (KH) cycle();
        key = 64'hffff0000ffff0000; total_len = 32'd99; mode = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (core_key_in !== m_key || core_mode_in !== 1'b0) begin errors++; $display("FAIL busy_start_key: got %h expected %h", core_key_in, m_key); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b expected 1", busy); end
        for (int k = 1; k <= 5; k++) begin
            core_out_en = 1'b1;
            cycle();
            if (k == 4) begin
                checks++;
                if (err_overrun !== 1'b0 || busy !== 1'b1 || out_cnt !== 32'd4) begin
                    errors++;
                    $display("FAIL ov_before: ov %b busy %b out %0d expected 0 1 4", err_overrun, busy, out_cnt);
                end
            end
        end
        halted = 1;
        core_out_en = 1'b0;
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ov_flag: got %b expected 1", err_overrun); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || out_cnt !== 32'd5) begin errors++; $display("FAIL ov_state: busy %b done %b out %0d", busy, done, out_cnt); end
        cycle();
        loop_en = 1;
    endtask

    task automatic test_reset_mid_stream();
        loop_en = 1; oe_budget = 1000000; rand_valid = 0; se_check = 1;
        do_start({$urandom, $urandom}, 1'b1, 16, 16);
        for (int i = 0; i < 50 && m_sent < 6; i++) cycle();
        rst = 1'b1;
        #1;
        checks++;
        if ({src_ready, core_key_in, core_mode_in, core_key_en, core_mpeg_in, core_mpeg_in_en,
             core_stream_end, busy, done, err_timeout, err_overrun, in_cnt, out_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: en %b busy %b in %0d key %h", core_mpeg_in_en, busy, in_cnt, core_key_in);
        end
        run_active = 0; se_check = 0; src_q.delete(); m_sent = 0; m_total = 0;
        pipe = '0; core_out_en = 1'b0; src_valid = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        checks++; if (busy !== 1'b0 || in_cnt !== 32'd0) begin errors++; $display("FAIL midrst_after: busy %b in %0d", busy, in_cnt); end
    endtask

    task automatic test_random_back_to_back();
        bit ok;
        int len;
        loop_en = 1; oe_budget = 1000000; rand_valid = 1; se_check = 1;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 24);
            do_start({$urandom, $urandom}, 1'($urandom_range(0, 1)), len, len);
            ok = 0;
            for (int i = 0; i < 600; i++) begin
                core_prog_full = ($urandom_range(0, 3) == 0);
                cycle();
                if (busy === 1'b0) begin
                    ok = 1;
                    break;
                end
            end
            core_prog_full = 1'b0;
            checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: done %b ok %b", it, done, ok); end
            checks++; if (in_cnt !== LW'(len) || out_cnt !== LW'(len) || rx_seen != len) begin errors++; $display("FAIL rnd%0d_counts: in %0d out %0d rx %0d expected %0d", it, in_cnt, out_cnt, rx_seen, len); end
            checks++; if (stall_cnt !== LW'(m_stall)) begin errors++; $display("FAIL rnd%0d_stall: got %0d expected %0d", it, stall_cnt, m_stall); end
            checks++; if (core_key_in !== m_key || core_mode_in !== m_mode) begin errors++; $display("FAIL rnd%0d_key: got %h/%b expected %h/%b", it, core_key_in, core_mode_in, m_key, m_mode); end
        end
        rand_valid = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; mode = 1'b0; total_len = '0;
        src_data = '0; src_valid = 1'b0; core_prog_full = 1'b0; core_out_en = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_prog_full();
        test_zero_len();
        test_timeout();
        test_overrun_busy_start();
        test_reset_mid_stream();
        test_random_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bhargava_stream_ctrl.md
Name: bhargava_stream_ctrl

Overview:
Single-clock sequencer in front of the bhargava scrambler/descrambler core. It loads the DES key and mode, streams a fixed-length MPEG byte stream from an upstream valid/ready source into the core while honouring mpeg_prog_full, and asserts stream_end after the last byte. It counts the core's output bytes, reports done when output equals input, and flags drain timeout or overrun. Replaces testbench-style feeding in system builds.

Parameters:
KEY_HOLD, 2, cycles core_key_en stays high (covers clk2x-domain key capture); range 1..15
TIMEOUT, 65535, max consecutive DRAIN cycles without core_out_en before ERROR
LEN_W, 32, width of length and byte counters

Ports:
clk  in  1  system clock (core clk)
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE, DONE or ERROR
key  in  64  DES key, captured on accepted start
mode  in  1  1 = decrypt, 0 = encrypt; captured on accepted start
total_len  in  LEN_W  stream length in bytes; captured on accepted start
src_data  in  8  upstream byte
src_valid  in  1  upstream byte valid
src_ready  out  1  controller accepts byte this cycle
core_key_in  out  64  to core key_in
core_mode_in  out  1  to core mode_in
core_key_en  out  1  to core key_en
core_mpeg_in  out  8  to core mpeg_in
core_mpeg_in_en  out  1  to core mpeg_in_en
core_stream_end  out  1  to core stream_end
core_prog_full  in  1  from core mpeg_prog_full
core_out_en  in  1  from core mpeg_out_en
busy  out  1  state not IDLE/DONE/ERROR
done  out  1  sticky, stream fully processed
err_timeout  out  1  sticky, drain watchdog expired
err_overrun  out  1  sticky, more output bytes than input
in_cnt  out  LEN_W  bytes sent to core
out_cnt  out  LEN_W  bytes received from core
stall_cnt  out  LEN_W  STREAM cycles with core_prog_full high

Behaviour:
- Reset: all outputs 0, state IDLE, captured registers 0. Reset mid-operation aborts immediately; no further core_mpeg_in_en; stream_end drops.
- States: IDLE, KEY_LOAD, STREAM, DRAIN, DONE, ERROR.
- IDLE/DONE/ERROR + start: capture key/mode/total_len; clear counters, done and err flags; go to KEY_LOAD. Start in any other state is ignored.
- KEY_LOAD: core_key_in/core_mode_in driven from captured regs (held stable in all states after capture); core_key_en high exactly KEY_HOLD cycles; then STREAM, or DRAIN if total_len==0.
- STREAM: src_ready = !core_prog_full && (in_cnt < total_len), combinational. Transfer = src_valid && src_ready. On transfer: next cycle core_mpeg_in = src_data, core_mpeg_in_en = 1 (latency 1); in_cnt increments on the transfer cycle. No transfer: core_mpeg_in_en = 0, core_mpeg_in holds. stall_cnt +1 per STREAM cycle with core_prog_full = 1 (saturating). On the transfer that makes in_cnt == total_len: go to DRAIN.
- core_stream_end: rises the cycle after the last transfer (same cycle as last core_mpeg_in_en), or on entry to DRAIN when total_len==0; stays high until next accepted start or reset.
- DRAIN: src_ready=0. Watchdog counts cycles since last core_out_en, reset on each core_out_en; reaching TIMEOUT -> ERROR with err_timeout=1. When out_cnt == total_len (including the cycle of the final core_out_en) -> DONE, done=1.
- out_cnt increments on core_out_en in STREAM and DRAIN only, saturating; core_out_en when out_cnt == total_len -> err_overrun=1, state ERROR. Ignored in IDLE/KEY_LOAD/DONE/ERROR.
- total_len==0: KEY_LOAD -> DRAIN -> DONE next cycle; no data bytes issued.
- Simultaneous core_prog_full and src_valid: no transfer; prog_full rising in same cycle as a transfer blocks the next transfer only.

Decomposition:
- Shared package bhargava_ctrl_pkg: state encoding enum, default TIMEOUT/KEY_HOLD constants.
- One natural sub-module: bhargava_drain_watchdog (loadable down-counter, kick and expire outputs). Everything else inline.

Test Plan:
- Reset then start, key=64'ha1b2c3d4e5f61234, mode=1, total_len=16, src always valid, core loops in->out after 4 cycles -> core_key_en high 2 cycles, 16 core_mpeg_in_en bytes in order, core_stream_end high from 16th byte, done=1, in_cnt=out_cnt=16.
- core_prog_full held high 10 cycles mid-stream -> src_ready=0 and no core_mpeg_in_en during those cycles, stall_cnt=10, byte order intact, done=1.
- total_len=0 -> no data bytes, core_stream_end=1, done=1 within KEY_HOLD+2 cycles of start.
- total_len=8, core returns only 7 bytes, TIMEOUT=100 -> err_timeout=1, state ERROR exactly 100 cycles after 7th core_out_en, done=0.
- total_len=4, core returns 5 bytes -> err_overrun=1 on 5th core_out_en; start while busy ignored; rst asserted mid-STREAM -> all outputs 0 immediately.
